if_axi_fetch: RTL and testbench

- Instruction-fetch bus master directly downstream of the IF stage.
- Takes the fetch PC each time IF issues a request and performs one single-beat AXI read to instruction memory.
- Returns the 32-bit instruction toward the IF/ID register and holds the pipeline (stall) while the read is outstanding.
- Handles branch/jump flush mid-transaction by discarding the stale beat.

---
 rtl/if_axi_fetch.sv | 121 ++++++++++++
 tb/tb_if_axi_fetch.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/if_axi_fetch.sv
// Instruction-fetch AXI read master: one single-beat read per IF request,
// stalls the pipeline while outstanding and drops beats made stale by a flush.
module if_axi_fetch #(
  parameter logic [3:0]  MASTER_ID = 4'd0,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [31:0] fetch_pc,
  input  logic        fetch_flush,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fetch_stall,
  output logic        fetch_err,
  output logic [3:0]  ARID,
  output logic [31:0] ARADDR,
  output logic [3:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [3:0]  RID,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state_r;
  logic   discard_r;
  logic   ar_hs_s;
  logic   r_last_hs_s;
  logic   drop_s;
  logic   unused_rid_s;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  assign ARID    = MASTER_ID;
  assign ARLEN   = 4'd0;
  assign ARSIZE  = 3'b010;
  assign ARBURST = 2'b01;

  assign unused_rid_s = ^RID;
  assign ar_hs_s      = ARVALID && ARREADY;
  assign r_last_hs_s  = RVALID && RREADY && RLAST;
  // A flush coinciding with the final beat makes that beat stale as well.
  assign drop_s       = discard_r || fetch_flush;
  assign fetch_stall  = (state_r != IDLE) || (fetch_req && !fetch_flush);

  // Fetch FSM with registered AXI handshakes and delivery pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      ARVALID     <= 1'b0;
      RREADY      <= 1'b0;
      ARADDR      <= 32'h0000_0000;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      discard_r   <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (fetch_req && !fetch_flush) begin
            ARADDR  <= word_align(fetch_pc);
            ARVALID <= 1'b1;
            state_r <= ADDR;
          end
        end
        ADDR: begin
          if (fetch_flush) begin
            discard_r <= 1'b1;
          end
          // The address is never withdrawn; a flush only marks the beat stale.
          if (ar_hs_s) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state_r <= DATA;
          end
        end
        DATA: begin
          if (r_last_hs_s) begin
            RREADY    <= 1'b0;
            state_r   <= IDLE;
            discard_r <= 1'b0;
            if (!drop_s) begin
              instr_valid <= 1'b1;
              if (RRESP == 2'b00) begin
                instr <= RDATA;
              end else begin
                instr     <= NOP_INSTR;
                fetch_err <= 1'b1;
              end
            end
          end else if (fetch_flush) begin
            discard_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          ARVALID   <= 1'b0;
          RREADY    <= 1'b0;
          discard_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_axi_fetch.sv
// Directed bench for if_axi_fetch: stimulus pushes expected AR addresses and
// delivered instructions into queues; a negedge monitor pops and compares.
module tb_if_axi_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req, fetch_flush;
  logic [31:0] fetch_pc;
  logic [31:0] instr;
  logic        instr_valid, fetch_stall, fetch_err;
  logic [3:0]  ARID, ARLEN;
  logic [31:0] ARADDR;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID, ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST, RVALID, RREADY;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] ar_q[$];
  logic [32:0] r_q[$];
  logic [31:0] last_instr;

  if_axi_fetch #(.MASTER_ID(4'd0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .fetch_flush(fetch_flush), .instr(instr), .instr_valid(instr_valid),
    .fetch_stall(fetch_stall), .fetch_err(fetch_err), .ARID(ARID),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .RID(RID), .RDATA(RDATA),
    .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 normal, 1 flush in ADDR, 2 flush in DATA, 3 flush with final beat
  task automatic fetch(input logic [31:0] pc, input int ardly, input int rdly,
                       input logic [31:0] data, input logic [1:0] resp,
                       input int mode, input int extra_beats);
    logic [31:0] a;
    a = {pc[31:2], 2'b00};
    ar_q.push_back(a);
    if (mode == 0) begin
      if (resp == 2'b00) begin
        r_q.push_back({1'b0, data});
        last_instr = data;
      end else begin
        r_q.push_back({1'b1, NOP});
        last_instr = NOP;
      end
    end
    fetch_req = 1'b1;
    fetch_pc  = pc;
    #1 check("stall_req", {31'd0, fetch_stall}, 32'd1);
    step();
    fetch_req = 1'b0;
    fetch_pc  = 32'hFFFF_FFFF;
    for (int i = 0; i < ardly; i++) begin
      fetch_flush = (mode == 1 && i == 0);
      #1;
      check("arvalid_hold", {31'd0, ARVALID}, 32'd1);
      check("araddr_hold", ARADDR, a);
      check("stall_addr", {31'd0, fetch_stall}, 32'd1);
      step();
    end
    fetch_flush = 1'b0;
    ARREADY = 1'b1;
    #1 check("arvalid_hs", {31'd0, ARVALID}, 32'd1);
    step();
    ARREADY = 1'b0;
    for (int i = 0; i < rdly; i++) begin
      fetch_flush = (mode == 2 && i == 0);
      #1;
      check("rready_wait", {31'd0, RREADY}, 32'd1);
      check("stall_data", {31'd0, fetch_stall}, 32'd1);
      step();
    end
    fetch_flush = 1'b0;
    for (int i = 0; i < extra_beats; i++) begin
      RVALID = 1'b1; RDATA = 32'hBAD0_0000 + i; RRESP = 2'b00; RLAST = 1'b0;
      step();
    end
    RVALID = 1'b1; RDATA = data; RRESP = resp; RLAST = 1'b1;
    fetch_flush = (mode == 3);
    #1;
    check("arvalid_one_cycle", {31'd0, ARVALID}, 32'd0);
    check("rready_beat", {31'd0, RREADY}, 32'd1);
    step();
    RVALID = 1'b0; RLAST = 1'b0; RDATA = 32'h0; RRESP = 2'b00;
    fetch_flush = 1'b0;
    #1;
    check("stall_release", {31'd0, fetch_stall}, 32'd0);
    check("rready_release", {31'd0, RREADY}, 32'd0);
    check("instr_valid_lat", {31'd0, instr_valid}, (mode == 0) ? 32'd1 : 32'd0);
    check("instr_value", instr, last_instr);
  endtask

  // Scoreboard monitor: pops expectations whenever the DUT presents a handshake or delivery.
  initial begin
    logic [31:0] ea;
    logic [32:0] er;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ARVALID && ARREADY) begin
          if (ar_q.size() == 0) begin
            check("ar_unexpected", 32'd1, 32'd0);
          end else begin
            ea = ar_q.pop_front();
            check("ar_addr", ARADDR, ea);
          end
        end
        if (instr_valid) begin
          if (r_q.size() == 0) begin
            check("iv_unexpected", 32'd1, 32'd0);
          end else begin
            er = r_q.pop_front();
            check("mon_instr", instr, er[31:0]);
            check("mon_err", {31'd0, fetch_err}, {31'd0, er[32]});
          end
        end else if (fetch_err) begin
          check("err_without_valid", 32'd1, 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; fetch_req = 1'b0; fetch_flush = 1'b0; fetch_pc = 32'h0;
    ARREADY = 1'b0; RID = 4'h5; RDATA = 32'h0; RRESP = 2'b00; RLAST = 1'b0; RVALID = 1'b0;
    last_instr = NOP;
    #2;
    check("rst_instr", instr, NOP);
    check("rst_arvalid", {31'd0, ARVALID}, 32'd0);
    check("rst_rready", {31'd0, RREADY}, 32'd0);
    check("rst_araddr", ARADDR, 32'h0);
    check("rst_pulses", {30'd0, instr_valid, fetch_err}, 32'd0);
    check("rst_stall", {31'd0, fetch_stall}, 32'd0);
    check("const_ar", {ARID, ARLEN, 1'b0, ARSIZE, ARBURST}, {4'd0, 4'd0, 1'b0, 3'b010, 2'b01});
    step();
    step();
    rst = 1'b0;
    step();

    fetch(32'h0000_0104, 0, 0, 32'h0051_0113, 2'b00, 0, 0);
    fetch(32'h0000_0206, 4, 0, 32'h00A0_0093, 2'b00, 0, 0);
    fetch(32'h0000_0100, 0, 2, 32'hDEAD_BEEF, 2'b00, 2, 0);
    fetch(32'h0000_0200, 0, 1, 32'h0020_8133, 2'b00, 0, 0);
    fetch(32'h0000_010C, 3, 0, 32'hCAFE_F00D, 2'b00, 1, 0);
    fetch(32'h0000_0110, 0, 0, 32'h1234_5678, 2'b10, 0, 0);
    fetch(32'h0000_0114, 1, 1, 32'h0041_8193, 2'b00, 0, 0);
    fetch(32'h0000_0118, 0, 0, 32'h5555_5555, 2'b00, 3, 0);
    fetch(32'h0000_011F, 0, 1, 32'h00C0_0213, 2'b00, 0, 2);

    // Request coinciding with a flush in IDLE is ignored.
    step();
    fetch_req = 1'b1; fetch_flush = 1'b1; fetch_pc = 32'h0000_0400;
    #1 check("req_flush_stall", {31'd0, fetch_stall}, 32'd0);
    step();
    fetch_req = 1'b0; fetch_flush = 1'b0;
    #1 check("req_flush_noar", {31'd0, ARVALID}, 32'd0);

    fetch(32'h0000_03FC, 2, 0, 32'hFFF0_0F13, 2'b11, 0, 0);
    fetch(32'h0000_0120, 0, 0, 32'h0062_8293, 2'b00, 0, 0);

    // Asynchronous reset while waiting in DATA.
    step();
    ar_q.push_back(32'h0000_0300);
    fetch_req = 1'b1; fetch_pc = 32'h0000_0300;
    step();
    fetch_req = 1'b0;
    ARREADY = 1'b1;
    step();
    ARREADY = 1'b0;
    #2 check("pre_rst_rready", {31'd0, RREADY}, 32'd1);
    rst = 1'b1;
    #1;
    check("arst_arvalid", {31'd0, ARVALID}, 32'd0);
    check("arst_rready", {31'd0, RREADY}, 32'd0);
    check("arst_instr", instr, NOP);
    check("arst_stall", {31'd0, fetch_stall}, 32'd0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_idle", {30'd0, ARVALID, fetch_stall}, 32'd0);

    step();
    check("ar_q_empty", ar_q.size(), 32'd0);
    check("r_q_empty", r_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
